dual_scan_ctrl: RTL and testbench
=================================

DUAL_SCAN_CTRL -- requirements
Module: dual_scan_ctrl

Interface
REQ-001 SHALL have the following ports, each listed as name, direction, width, meaning:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- go  in  1  start a capture session; sampled only in IDLE
- stop  in  1  end the session after the current transfer completes; sticky until IDLE
- abort  in  1  flush both scanners immediately
- link_ready  in  1  downstream can accept a buffer
- sN_count  in  8  scanner N buffer fill, where N = 0 or 1
- sN_ready_second  in  1  scanner N fill has reached at least 80
- sN_start_second  in  1  scanner N fill has reached at least 90
- sN_start_scan  out  1  one-cycle pulse that starts scanner N
- sN_standby  out  1  one-cycle pulse that sends scanner N to standby
- sN_transfer  out  1  level; scanner N drains while high
- sN_flush  out  1  level; scanner N flushes while high
- cur  out  1  index of the scanner currently filling
- busy  out  1  high in every state except IDLE
- words_sent  out  16  words drained since the last go
- err  out  1  sticky link-timeout flag

Function
REQ-002 SHALL implement the FSM states IDLE, SCAN, ARM, WAIT_FULL, XFER and FLUSH; "oth" below means the scanner other than cur.
REQ-003 IDLE: on go=1, SHALL pulse s[cur]_start_scan for one cycle, clear words_sent and err, and move to SCAN.
REQ-004 SCAN: when s[cur]_ready_second=1, SHALL pulse s[oth]_standby for one cycle and move to ARM.
REQ-005 ARM: when s[cur]_start_second=1, SHALL pulse s[oth]_start_scan for one cycle and move to WAIT_FULL.
- If stop is latched, SHALL suppress that pulse and move to WAIT_FULL anyway.
REQ-006 WAIT_FULL: when s[cur]_count==100 and link_ready=1, SHALL raise s[cur]_transfer and move to XFER.
REQ-007 XFER: SHALL hold s[cur]_transfer high and add 1 to words_sent each cycle that s[cur]_count!=0.
- words_sent SHALL saturate at 16'hFFFF.
REQ-008 XFER exit: on the first cycle with s[cur]_count==0, SHALL drop transfer and toggle cur.
- If stop is latched, SHALL go to IDLE.
- Otherwise SHALL go to SCAN; the new cur is already scanning.
REQ-009 Timeout: an 8-bit counter SHALL run in WAIT_FULL while count==100 and link_ready=0.
- On reaching 255, SHALL set err and enter FLUSH.
- The counter SHALL clear on leaving WAIT_FULL.
REQ-010 abort=1 in any non-IDLE state SHALL enter FLUSH on the next edge; abort SHALL take priority over every other transition.
REQ-011 FLUSH: SHALL hold s0_flush and s1_flush high and all transfer outputs low.
- SHALL return to IDLE on the first cycle with s0_count==0 and s1_count==0.
- SHALL clear the stop latch on that return.
REQ-012 go outside IDLE SHALL be ignored; stop in IDLE SHALL be ignored and not latched.
REQ-013 At most one sN_transfer SHALL be high in any cycle; transfer and flush for the same scanner SHALL never be high together.
REQ-014 All outputs SHALL be registered; a pulse output SHALL be high for exactly one clk cycle.
REQ-015 Simultaneous stop and a transition condition SHALL latch stop and still take the transition on the same edge.

Reset
REQ-016 rst=0 SHALL force state IDLE immediately, regardless of clk.
- cur=0, words_sent=0, err=0, stop latch=0, timeout counter=0.
- All sN_* outputs=0, busy=0.
REQ-017 Reset asserted mid-transfer SHALL drop every output low immediately; after release the block SHALL resume only on a new go.

Verification
REQ-018 go, s0_count ramps 0->100 with ready_second at 80 and start_second at 90 -> s1_standby pulse at 80, s1_start_scan pulse at 90, state WAIT_FULL at 100.
REQ-019 link_ready=1 at s0_count=100, count then decrements 1/cycle -> s0_transfer high for 100 cycles, words_sent=100, cur=1, state SCAN.
REQ-020 stop asserted during cur=1 SCAN -> no s0_start_scan pulse in ARM; after s1 drains, state IDLE, words_sent=200, busy=0.
REQ-021 link_ready held 0 for 255 cycles at count=100 -> err=1, both flush outputs high until both counts are 0, then IDLE.
REQ-022 abort in the same cycle as the WAIT_FULL->XFER condition -> FLUSH entered, no transfer output ever high.
REQ-023 rst pulsed low mid-XFER -> all outputs 0 immediately; a following go restarts with cur=0 and words_sent=0.

Source files
------------

// File: rtl/dual_scan_ctrl.sv
// dual_scan_ctrl: ping-pong control of two scanners, draining each full buffer to the link.
module dual_scan_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        stop,
  input  logic        abort,
  input  logic        link_ready,
  input  logic [7:0]  s0_count,
  input  logic        s0_ready_second,
  input  logic        s0_start_second,
  input  logic [7:0]  s1_count,
  input  logic        s1_ready_second,
  input  logic        s1_start_second,
  output logic        s0_start_scan,
  output logic        s0_standby,
  output logic        s0_transfer,
  output logic        s0_flush,
  output logic        s1_start_scan,
  output logic        s1_standby,
  output logic        s1_transfer,
  output logic        s1_flush,
  output logic        cur,
  output logic        busy,
  output logic [15:0] words_sent,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, SCAN, ARM, WAIT_FULL, XFER, FLUSH} state_t;
  state_t      state;
  logic [1:0]  start_scan, standby, transfer, flush;
  logic [7:0]  tmo;
  logic        stop_l;
  logic [7:0]  cnt_c;
  logic        rdy_c, st_c, stop_eff;
  assign cnt_c    = cur ? s1_count : s0_count;
  assign rdy_c    = cur ? s1_ready_second : s0_ready_second;
  assign st_c     = cur ? s1_start_second : s0_start_second;
  // a stop arriving on the same edge as a decision already counts
  assign stop_eff = stop_l | stop;
  assign {s1_start_scan, s0_start_scan} = start_scan;
  assign {s1_standby, s0_standby}       = standby;
  assign {s1_transfer, s0_transfer}     = transfer;
  assign {s1_flush, s0_flush}           = flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_scan <= '0;
      standby    <= '0;
      transfer   <= '0;
      flush      <= '0;
      tmo        <= '0;
      stop_l     <= 1'b0;
      cur        <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      err        <= 1'b0;
    end else begin
      start_scan <= '0;
      standby    <= '0;
      if (state != IDLE && stop) stop_l <= 1'b1;
      if (state != IDLE && abort) begin
        state    <= FLUSH;
        transfer <= '0;
        flush    <= 2'b11;
        tmo      <= '0;
      end else begin
        case (state)
          IDLE: if (go) begin
            start_scan[cur] <= 1'b1;
            words_sent      <= '0;
            err             <= 1'b0;
            busy            <= 1'b1;
            state           <= SCAN;
          end
          SCAN: if (rdy_c) begin
            standby[~cur] <= 1'b1;
            state         <= ARM;
          end
          ARM: if (st_c) begin
            start_scan[~cur] <= !stop_eff;
            state            <= WAIT_FULL;
          end
          WAIT_FULL: if (cnt_c == 8'd100 && link_ready) begin
            transfer[cur] <= 1'b1;
            tmo           <= '0;
            state         <= XFER;
          end else if (cnt_c == 8'd100) begin
            // the 255th stalled cycle is the timeout
            tmo <= (tmo == 8'd254) ? 8'd0 : tmo + 8'd1;
            if (tmo == 8'd254) begin
              err   <= 1'b1;
              flush <= 2'b11;
              state <= FLUSH;
            end
          end
          XFER: if (cnt_c == 8'd0) begin
            transfer <= '0;
            cur      <= ~cur;
            state    <= stop_eff ? IDLE : SCAN;
            busy     <= !stop_eff;
            if (stop_eff) stop_l <= 1'b0;
          end else if (words_sent != 16'hFFFF) begin
            words_sent <= words_sent + 16'd1;
          end
          FLUSH: if (s0_count == 8'd0 && s1_count == 8'd0) begin
            flush  <= '0;
            stop_l <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dual_scan_ctrl.sv
// tb_dual_scan_ctrl: table-driven directed check of dual_scan_ctrl sessions, timeout, abort and reset.
module tb_dual_scan_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic go = 1'b0, stop = 1'b0, abort = 1'b0, link_ready = 1'b0;
  logic [7:0] s0_count = 8'd0, s1_count = 8'd0;
  logic s0_ready_second, s0_start_second, s1_ready_second, s1_start_second;
  logic s0_start_scan, s0_standby, s0_transfer, s0_flush;
  logic s1_start_scan, s1_standby, s1_transfer, s1_flush;
  logic cur, busy, err;
  logic [15:0] words_sent;
  int checks = 0, failures = 0;
  assign s0_ready_second = s0_count >= 8'd80;
  assign s0_start_second = s0_count >= 8'd90;
  assign s1_ready_second = s1_count >= 8'd80;
  assign s1_start_second = s1_count >= 8'd90;
  always #5 clk = ~clk;
  dual_scan_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop), .abort(abort), .link_ready(link_ready),
    .s0_count(s0_count), .s0_ready_second(s0_ready_second), .s0_start_second(s0_start_second),
    .s1_count(s1_count), .s1_ready_second(s1_ready_second), .s1_start_second(s1_start_second),
    .s0_start_scan(s0_start_scan), .s0_standby(s0_standby), .s0_transfer(s0_transfer), .s0_flush(s0_flush),
    .s1_start_scan(s1_start_scan), .s1_standby(s1_standby), .s1_transfer(s1_transfer), .s1_flush(s1_flush),
    .cur(cur), .busy(busy), .words_sent(words_sent), .err(err)
  );
  // exp bits: {s0_ss,s0_sb,s0_tr,s0_fl, s1_ss,s1_sb,s1_tr,s1_fl, cur,busy,err}
  typedef struct {
    logic go, stop, abort, lr;
    logic [7:0] c0, c1;
    logic [10:0] exp;
    logic [15:0] ew;
  } vec_t;
  vec_t tbl[33];
  task automatic set(input int i, input logic g, s, a, l, input logic [7:0] c0, c1,
                     input logic [10:0] e, input logic [15:0] w);
    tbl[i] = '{g, s, a, l, c0, c1, e, w};
  endtask
  task automatic check(input string nm, input logic [10:0] e, input logic [15:0] w);
    logic [10:0] obs;
    obs = {s0_start_scan, s0_standby, s0_transfer, s0_flush,
           s1_start_scan, s1_standby, s1_transfer, s1_flush, cur, busy, err};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL %s outputs got=%b want=%b", nm, obs, e);
    end
    checks++;
    if (words_sent !== w) begin
      failures++;
      $display("FAIL %s words_sent got=%0d want=%0d", nm, words_sent, w);
    end
  endtask
  task automatic apply(input vec_t t, input string nm);
    go = t.go; stop = t.stop; abort = t.abort; link_ready = t.lr;
    s0_count = t.c0; s1_count = t.c1;
    @(posedge clk); #1;
    check(nm, t.exp, t.ew);
  endtask
  task automatic run(input int a, input int b);
    for (int i = a; i <= b; i++) apply(tbl[i], $sformatf("vec%0d", i));
  endtask
  initial begin
    vec_t d;
    set(0,  1,0,0,0, 8'd0,   8'd0, 11'b1000_0000_010, 16'd0);
    set(1,  0,0,0,0, 8'd50,  8'd0, 11'b0000_0000_010, 16'd0);
    set(2,  0,0,0,0, 8'd80,  8'd0, 11'b0000_0100_010, 16'd0);
    set(3,  0,0,0,0, 8'd85,  8'd0, 11'b0000_0000_010, 16'd0);
    set(4,  0,0,0,0, 8'd90,  8'd0, 11'b0000_1000_010, 16'd0);
    set(5,  1,0,0,0, 8'd95,  8'd0, 11'b0000_0000_010, 16'd0);
    set(6,  0,0,0,0, 8'd100, 8'd0, 11'b0000_0000_010, 16'd0);
    set(7,  0,0,0,1, 8'd100, 8'd0, 11'b0010_0000_010, 16'd0);
    set(8,  0,0,0,0, 8'd0,   8'd0, 11'b0000_0000_110, 16'd100);
    set(9,  0,1,0,0, 8'd0,   8'd50, 11'b0000_0000_110, 16'd100);
    set(10, 0,0,0,0, 8'd0,   8'd80, 11'b0100_0000_110, 16'd100);
    set(11, 0,0,0,0, 8'd0,   8'd90, 11'b0000_0000_110, 16'd100);
    set(12, 0,0,0,1, 8'd0,   8'd100, 11'b0000_0010_110, 16'd100);
    set(13, 0,0,0,0, 8'd0,   8'd0, 11'b0000_0000_000, 16'd200);
    set(14, 0,1,0,0, 8'd0,   8'd0, 11'b0000_0000_000, 16'd200);
    set(15, 1,0,0,0, 8'd0,   8'd0, 11'b1000_0000_010, 16'd0);
    set(16, 0,0,0,0, 8'd80,  8'd0, 11'b0000_0100_010, 16'd0);
    set(17, 0,0,0,0, 8'd90,  8'd0, 11'b0000_1000_010, 16'd0);
    set(18, 0,0,0,0, 8'd100, 8'd0, 11'b0001_0001_011, 16'd0);
    set(19, 0,0,0,0, 8'd5,   8'd0, 11'b0001_0001_011, 16'd0);
    set(20, 0,0,0,0, 8'd0,   8'd3, 11'b0001_0001_011, 16'd0);
    set(21, 0,0,0,0, 8'd0,   8'd0, 11'b0000_0000_001, 16'd0);
    set(22, 1,0,0,0, 8'd0,   8'd0, 11'b1000_0000_010, 16'd0);
    set(23, 0,0,0,0, 8'd80,  8'd0, 11'b0000_0100_010, 16'd0);
    set(24, 0,0,0,0, 8'd90,  8'd0, 11'b0000_1000_010, 16'd0);
    set(25, 0,0,1,1, 8'd100, 8'd0, 11'b0001_0001_010, 16'd0);
    set(26, 0,0,0,0, 8'd0,   8'd0, 11'b0000_0000_000, 16'd0);
    set(27, 1,0,0,0, 8'd0,   8'd0, 11'b1000_0000_010, 16'd0);
    set(28, 0,0,0,0, 8'd80,  8'd0, 11'b0000_0100_010, 16'd0);
    set(29, 0,0,0,0, 8'd90,  8'd0, 11'b0000_1000_010, 16'd0);
    set(30, 0,0,0,1, 8'd100, 8'd0, 11'b0010_0000_010, 16'd0);
    set(31, 0,0,0,0, 8'd99,  8'd0, 11'b0010_0000_010, 16'd1);
    set(32, 0,0,0,0, 8'd98,  8'd0, 11'b0010_0000_010, 16'd2);
    #1 check("reset", 11'b0, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run(0, 7);
    for (int i = 100; i >= 1; i--) begin
      d = '{1'b0, 1'b0, 1'b0, 1'b0, 8'(i), 8'd0, 11'b0010_0000_010, 16'(101 - i)};
      apply(d, "drain0");
    end
    run(8, 12);
    for (int i = 100; i >= 1; i--) begin
      d = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'(i), 11'b0000_0010_110, 16'(201 - i)};
      apply(d, "drain1");
    end
    run(13, 17);
    for (int i = 0; i < 254; i++) begin
      d = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd100, 8'd0, 11'b0000_0000_010, 16'd0};
      apply(d, "stall");
    end
    run(18, 32);
    #2 rst = 1'b0;
    #1 check("async_reset", 11'b0, 16'd0);
    @(posedge clk); #1 rst = 1'b1;
    d = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd97, 8'd0, 11'b0, 16'd0};
    apply(d, "post_reset_idle");
    d = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b1000_0000_010, 16'd0};
    apply(d, "restart");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
